// File: rtl/dpc_pkg.sv
// Shared definitions for the bracket-matching sequencer: instruction codes,
// seek state encoding and BCD depth limits.
package dpc_pkg;

   localparam logic [3:0] INSN_NOP        = 4'h0;
   localparam logic [3:0] INSN_LOOP_BEGIN = 4'hA;
   localparam logic [3:0] INSN_LOOP_END   = 4'hB;
   localparam logic [3:0] INSN_HALT       = 4'hF;

   localparam logic [7:0] DEPTH_ONE = 8'h01;
   localparam logic [7:0] DEPTH_MAX = 8'h99;

   typedef enum logic [2:0] {
      SEEK_IDLE,
      SEEK_CLEAR,
      SEEK_PUSH,
      SEEK_SETTLE,
      SEEK_FETCH,
      SEEK_EVAL,
      SEEK_DONE,
      SEEK_ERROR
   } seek_state_e;

   // Bracket class relative to the seek direction
   typedef enum logic [1:0] {
      BRK_OTHER,
      BRK_SAME,
      BRK_CLOSE,
      BRK_HALT
   } brk_class_e;

endpackage

// File: rtl/loop_seek_ctrl.sv
// Walks the IP one instruction at a time to the matching bracket, tracking
// nesting depth on the external BCD loop counter. All outputs are registered.
module loop_seek_ctrl
   import dpc_pkg::*;
#(
   parameter int INSN_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              request_i,
   input  logic              dir_i,
   input  logic              abort_i,
   output logic              ip_req_o,
   output logic              ip_reverse_o,
   input  logic              ip_ack_i,
   input  logic [INSN_W-1:0] insn_i,
   output logic              loop_step_o,
   output logic              loop_reverse_o,
   output logic              loop_clr_o,
   input  logic [7:0]        loop_count_i,
   input  logic              loop_overflow_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
);

   seek_state_e       state_q, state_d;
   logic              dir_q, dir_d;
   logic [INSN_W-1:0] insn_q, insn_d;
   logic              ip_req_q, ip_req_d;
   logic              step_q, step_d;
   logic              step_rev_q, step_rev_d;
   logic              clr_q, clr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   function automatic brk_class_e classify(input logic [INSN_W-1:0] insn, input logic rev);
      logic [INSN_W-1:0] same_c;
      logic [INSN_W-1:0] close_c;
      same_c  = rev ? INSN_W'(INSN_LOOP_END)   : INSN_W'(INSN_LOOP_BEGIN);
      close_c = rev ? INSN_W'(INSN_LOOP_BEGIN) : INSN_W'(INSN_LOOP_END);
      if (insn == same_c)                 return BRK_SAME;
      else if (insn == close_c)           return BRK_CLOSE;
      else if (insn == INSN_W'(INSN_HALT)) return BRK_HALT;
      else                                return BRK_OTHER;
   endfunction

   // Output "_d" values describe the cycle spent in state_d, so every
   // pulse lines up with the state it belongs to once registered.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      insn_d     = insn_q;
      ip_req_d   = 1'b0;
      step_d     = 1'b0;
      step_rev_d = 1'b0;
      clr_d      = 1'b0;
      done_d     = 1'b0;

      if (abort_i && state_q != SEEK_IDLE) begin
         state_d = SEEK_IDLE;
         clr_d   = 1'b1;
      end else begin
         unique case (state_q)
            SEEK_IDLE: begin
               if (request_i && !abort_i) begin
                  dir_d   = dir_i;
                  state_d = SEEK_CLEAR;
                  clr_d   = 1'b1;
               end
            end
            SEEK_CLEAR: begin
               state_d = SEEK_PUSH;
               step_d  = 1'b1;
            end
            SEEK_PUSH: state_d = SEEK_SETTLE;
            SEEK_SETTLE: begin
               if (loop_overflow_i) begin
                  state_d = SEEK_ERROR;
               end else begin
                  state_d  = SEEK_FETCH;
                  ip_req_d = 1'b1;
               end
            end
            SEEK_FETCH: begin
               if (ip_ack_i) begin
                  insn_d  = insn_i;
                  state_d = SEEK_EVAL;
               end else begin
                  ip_req_d = 1'b1;
               end
            end
            SEEK_EVAL: begin
               unique case (classify(insn_q, dir_q))
                  BRK_SAME: begin
                     if (loop_count_i == DEPTH_MAX) begin
                        state_d = SEEK_ERROR;
                     end else begin
                        step_d  = 1'b1;
                        state_d = SEEK_SETTLE;
                     end
                  end
                  BRK_CLOSE: begin
                     step_d     = 1'b1;
                     step_rev_d = 1'b1;
                     if (loop_count_i == DEPTH_ONE) begin
                        state_d = SEEK_DONE;
                        done_d  = 1'b1;
                     end else begin
                        state_d = SEEK_SETTLE;
                     end
                  end
                  BRK_HALT: state_d = SEEK_ERROR;
                  default: begin
                     state_d  = SEEK_FETCH;
                     ip_req_d = 1'b1;
                  end
               endcase
            end
            SEEK_DONE:  state_d = SEEK_IDLE;
            SEEK_ERROR: state_d = SEEK_ERROR;
            default:    state_d = SEEK_IDLE;
         endcase
      end

      busy_d  = state_d inside {SEEK_CLEAR, SEEK_PUSH, SEEK_SETTLE, SEEK_FETCH, SEEK_EVAL};
      error_d = (state_d == SEEK_ERROR);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= SEEK_IDLE;
         dir_q      <= 1'b0;
         insn_q     <= '0;
         ip_req_q   <= 1'b0;
         step_q     <= 1'b0;
         step_rev_q <= 1'b0;
         clr_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         insn_q     <= insn_d;
         ip_req_q   <= ip_req_d;
         step_q     <= step_d;
         step_rev_q <= step_rev_d;
         clr_q      <= clr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign ip_req_o       = ip_req_q;
   assign ip_reverse_o   = dir_q;
   assign loop_step_o    = step_q;
   assign loop_reverse_o = step_rev_q;
   assign loop_clr_o     = clr_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign error_o        = error_q;

endmodule
